// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the dual-clock FIFO: issues read strobes against the fill count,
// absorbs the one-cycle read latency in a 4-entry skid buffer and presents a valid/ready stream.
module fifo_rd_stream #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             xclk,
    input  logic             ax_rst,
    input  logic             en,
    input  logic [CW-1:0]    f_fullcount,
    output logic             f_rd,
    input  logic [WIDTH-1:0] f_rddata,
    input  logic             f_rd_data_valid,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [31:0]      words_out
);

    logic [WIDTH-1:0] skid_mem [4];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [2:0]       occ;
    logic [3:0]       occ_plus_inflight;
    logic             pop;

    // Counting the word already in flight reserves its slot, so the read strobe never
    // depends on m_ready and the buffer can never be overrun.
    assign occ_plus_inflight = {1'b0, occ} + {3'b000, f_rd_data_valid};
    assign f_rd              = en && (f_fullcount != '0) && (occ_plus_inflight <= 4'd3);

    assign m_valid = (occ != 3'd0);
    assign m_data  = skid_mem[rd_ptr];
    assign pop     = m_valid && m_ready;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge xclk or posedge ax_rst) begin
        if (ax_rst) begin
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            occ       <= 3'd0;
            words_out <= 32'd0;
        end else begin
            if (f_rd_data_valid) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 2'd1;
                words_out <= words_out + 32'd1;
            end
            occ <= occ + {2'b00, f_rd_data_valid} - {2'b00, pop};
        end
    end

    // NOTE: the data storage has no reset; occ gates m_valid, so stale entries are never observed.
    always_ff @(posedge xclk) begin
        if (f_rd_data_valid) begin
            skid_mem[wr_ptr] <= f_rddata;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a behavioural FIFO with one-cycle read latency feeds the DUT,
// a scoreboard checks stream order, and invariants are checked every cycle.
module tb_fifo_rd_stream;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             xclk = 1'b0;
    logic             ax_rst;
    logic             en;
    logic [CW-1:0]    f_fullcount;
    logic             f_rd;
    logic [WIDTH-1:0] f_rddata;
    logic             f_rd_data_valid;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [31:0]      words_out;

    fifo_rd_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .xclk            (xclk),
        .ax_rst          (ax_rst),
        .en              (en),
        .f_fullcount     (f_fullcount),
        .f_rd            (f_rd),
        .f_rddata        (f_rddata),
        .f_rd_data_valid (f_rd_data_valid),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .words_out       (words_out)
    );

    always #5 xclk = ~xclk;

    typedef struct {
        int         nwords;
        logic [7:0] base;
        int         ready_div;
        int         exp_words;
        logic [7:0] exp_last;
    } vec_t;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         occ_model;
    int         cyc = 0;
    int         rd_pulses;
    int         beats;
    logic [7:0] last_data;
    logic       s_rd;
    logic       s_valid;
    logic [7:0] s_data;
    logic       prev_stall;
    logic [7:0] prev_data;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        f_fullcount = CW'(fifo_q.size());
    endtask

    // One clock: sample and check at the falling edge, then update the FIFO model after the rising edge.
    task automatic step();
        logic       dv_s;
        logic       beat_s;
        logic [7:0] exp_w;
        @(negedge xclk);
        s_rd    = f_rd;
        s_valid = m_valid;
        s_data  = m_data;
        beat_s  = m_valid && m_ready;
        dv_s    = f_rd_data_valid;
        check("no_underrun", 32'(f_rd && (f_fullcount == '0)), 32'd0);
        check("no_overflow", 32'(dv_s && (occ_model == 4)), 32'd0);
        check("m_valid_vs_occ", 32'(m_valid), 32'(occ_model != 0));
        if (prev_stall) begin
            check("stall_valid_hold", 32'(m_valid), 32'd1);
            check("stall_data_hold", 32'(m_data), 32'(prev_data));
        end
        if (beat_s) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL beat_expected: got beat with data %0h, required no beat", m_data);
            end else begin
                exp_w = exp_q.pop_front();
                check("beat_data", 32'(m_data), 32'(exp_w));
            end
            beats++;
            last_data = m_data;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (s_rd) rd_pulses++;
        @(posedge xclk);
        #1;
        occ_model = occ_model + int'(dv_s) - int'(beat_s);
        if (s_rd && fifo_q.size() > 0) begin
            f_rddata        = fifo_q.pop_front();
            f_rd_data_valid = 1'b1;
        end else begin
            f_rd_data_valid = 1'b0;
        end
        f_fullcount = CW'(fifo_q.size());
        cyc++;
    endtask

    task automatic do_reset();
        ax_rst          = 1'b1;
        en              = 1'b0;
        m_ready         = 1'b0;
        f_rd_data_valid = 1'b0;
        f_rddata        = '0;
        fifo_q.delete();
        exp_q.delete();
        f_fullcount = '0;
        occ_model   = 0;
        prev_stall  = 1'b0;
        rd_pulses   = 0;
        beats       = 0;
        repeat (2) @(posedge xclk);
        #1;
        ax_rst = 1'b0;
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_words_out", words_out, 32'd0);
    endtask

    // ready_div > 0: m_ready high every ready_div-th cycle; 0: m_ready left as is.
    task automatic drain(input int max_cycles, input int ready_div);
        int n = 0;
        while ((fifo_q.size() > 0 || f_rd_data_valid || occ_model > 0) && n < max_cycles) begin
            if (ready_div > 0) m_ready = ((cyc % ready_div) == 0);
            step();
            n++;
        end
        check("drained_in_time", 32'(fifo_q.size() == 0 && !f_rd_data_valid && occ_model == 0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[6];
        logic [5:0] rd_bits;
        logic [5:0] val_bits;
        logic [7:0] single_data;
        logic [19:0] beat_bits;
        int         pushed;
        int         n;

        vecs[0] = '{1,  8'hA5, 1, 1,  8'hA5};
        vecs[1] = '{4,  8'h10, 1, 4,  8'h13};
        vecs[2] = '{16, 8'h01, 1, 16, 8'h10};
        vecs[3] = '{5,  8'h30, 2, 5,  8'h34};
        vecs[4] = '{9,  8'h80, 3, 9,  8'h88};
        vecs[5] = '{3,  8'hFE, 4, 3,  8'h00};

        ax_rst = 1'b1;
        do_reset();

        foreach (vecs[v]) begin
            do_reset();
            en = 1'b1;
            for (int i = 0; i < vecs[v].nwords; i++) push_word(8'(vecs[v].base + 8'(i)));
            drain(400, vecs[v].ready_div);
            check("vec_words_out", words_out, 32'(vecs[v].exp_words));
            check("vec_last_data", 32'(last_data), 32'(vecs[v].exp_last));
            check("vec_rd_pulses", 32'(rd_pulses), 32'(vecs[v].exp_words));
        end

        // Single word: read strobe in cycle 0, valid in cycle 2
        do_reset();
        en = 1'b1;
        m_ready = 1'b1;
        push_word(8'hA5);
        rd_bits = '0;
        val_bits = '0;
        single_data = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            rd_bits[i]  = s_rd;
            val_bits[i] = s_valid;
            if (i == 2) single_data = s_data;
        end
        check("single_rd_trace", 32'(rd_bits), 32'h01);
        check("single_valid_trace", 32'(val_bits), 32'h04);
        check("single_data", 32'(single_data), 32'hA5);
        check("single_words_out", words_out, 32'd1);

        // Streaming 16 words: beats in cycles 2..17, no bubbles
        do_reset();
        en = 1'b1;
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) push_word(8'(i));
        beat_bits = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            beat_bits[i] = s_valid;
        end
        check("stream_beat_trace", 32'(beat_bits), 32'h3FFFC);
        check("stream_words_out", words_out, 32'd16);
        check("stream_last_data", 32'(last_data), 32'h10);

        // Backpressure: four reads fill the buffer, first word held
        do_reset();
        en = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'(8'h21 + 8'(i)));
        repeat (10) step();
        check("bp_rd_pulses", 32'(rd_pulses), 32'd4);
        check("bp_occ", 32'(occ_model), 32'd4);
        check("bp_m_valid", 32'(m_valid), 32'd1);
        check("bp_m_data", 32'(m_data), 32'h21);
        m_ready = 1'b1;
        drain(100, 0);
        check("bp_words_out", words_out, 32'd8);
        check("bp_last_data", 32'(last_data), 32'h28);

        // Random m_ready over 200 words
        do_reset();
        en = 1'b1;
        pushed = 0;
        n = 0;
        while (beats < 200 && n < 3000) begin
            m_ready = 1'($urandom_range(0, 1));
            if (pushed < 200 && fifo_q.size() < DEPTH) begin
                push_word(8'(pushed * 7 + 3));
                pushed++;
            end
            step();
            n++;
        end
        check("rand_beats", 32'(beats), 32'd200);
        check("rand_words_out", words_out, 32'd200);
        check("rand_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // en drops right after a read is issued: the in-flight word still arrives
        do_reset();
        en = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) push_word(8'(8'h41 + 8'(i)));
        step();
        check("en_first_rd", 32'(s_rd), 32'd1);
        en = 1'b0;
        repeat (8) step();
        check("en_rd_pulses", 32'(rd_pulses), 32'd1);
        check("en_words_out", words_out, 32'd1);
        check("en_inflight_data", 32'(last_data), 32'h41);
        en = 1'b1;
        drain(100, 0);
        check("en_resume_words_out", words_out, 32'd6);
        check("en_resume_last", 32'(last_data), 32'h46);

        // Reset mid-stream with three words buffered and one in flight
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'(8'h61 + 8'(i)));
        n = 0;
        while (occ_model != 3 && n < 20) begin
            step();
            n++;
        end
        check("rst_reached_occ3", 32'(occ_model), 32'd3);
        ax_rst = 1'b1;
        #1;
        check("rst_mid_m_valid", 32'(m_valid), 32'd0);
        check("rst_mid_words_out", words_out, 32'd0);
        fifo_q.delete();
        exp_q.delete();
        f_fullcount     = '0;
        f_rd_data_valid = 1'b0;
        occ_model       = 0;
        prev_stall      = 1'b0;
        #1;
        check("rst_mid_f_rd", 32'(f_rd), 32'd0);
        @(posedge xclk);
        #1;
        ax_rst  = 1'b0;
        m_ready = 1'b1;
        repeat (3) step();
        check("rst_after_words_out", words_out, 32'd0);
        check("rst_after_m_valid", 32'(m_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
